// File: rtl/decimator_pkg.sv
// Shared constants and helpers for the boxcar decimator: Q format, reciprocal table, window lengths.
package decimator_pkg;

    localparam int unsigned ADC_W    = 12;
    localparam int unsigned ACC_W    = 30;
    localparam int unsigned OUT_W    = 32;
    localparam int unsigned MODE_W   = 4;
    localparam int unsigned ML_W     = 3;
    localparam int unsigned CNT_W    = 17;
    localparam int unsigned RECIP_W  = 33;
    localparam int unsigned PROD_W   = 64;
    localparam int unsigned MODE_MAX = 5;
    localparam int unsigned FRAC     = 18;
    localparam int unsigned SHIFT    = OUT_W - FRAC;

    localparam logic [RECIP_W-1:0] RECIP0 = 33'd4294967296;
    localparam logic [RECIP_W-1:0] RECIP1 = 33'd429496730;
    localparam logic [RECIP_W-1:0] RECIP2 = 33'd42949673;
    localparam logic [RECIP_W-1:0] RECIP3 = 33'd4294967;
    localparam logic [RECIP_W-1:0] RECIP4 = 33'd429497;
    localparam logic [RECIP_W-1:0] RECIP5 = 33'd42950;

    // Offset binary to two's complement: flip the MSB.
    function automatic logic signed [ADC_W-1:0] ob_to_s(input logic [ADC_W-1:0] a);
        return $signed({~a[ADC_W-1], a[ADC_W-2:0]});
    endfunction

    function automatic logic [ML_W-1:0] clamp_mode(input logic [MODE_W-1:0] m);
        return (m > MODE_W'(MODE_MAX)) ? ML_W'(MODE_MAX) : m[ML_W-1:0];
    endfunction

    function automatic logic [RECIP_W-1:0] recip(input logic [ML_W-1:0] m);
        case (m)
            3'd0:    return RECIP0;
            3'd1:    return RECIP1;
            3'd2:    return RECIP2;
            3'd3:    return RECIP3;
            3'd4:    return RECIP4;
            default: return RECIP5;
        endcase
    endfunction

    // Count value of the last sample in a window (N - 1).
    function automatic logic [CNT_W-1:0] win_last(input logic [ML_W-1:0] m);
        case (m)
            3'd0:    return CNT_W'(0);
            3'd1:    return CNT_W'(9);
            3'd2:    return CNT_W'(99);
            3'd3:    return CNT_W'(999);
            3'd4:    return CNT_W'(9999);
            default: return CNT_W'(99999);
        endcase
    endfunction

endpackage

// File: rtl/decimator_if.sv
// Sample-in / decimated-out bundle between ADC capture and the DDS processing path.
interface decimator_if;
    import decimator_pkg::*;

    logic [ADC_W-1:0]  adc_in;
    logic              adc_valid;
    logic              sync;
    logic [MODE_W-1:0] Mode;
    logic [OUT_W-1:0]  dec_out;
    logic              dec_valid;

    modport master (output adc_in, adc_valid, sync, Mode, input dec_out, dec_valid);
    modport slave  (input adc_in, adc_valid, sync, Mode, output dec_out, dec_valid);

endinterface

// File: rtl/dec_scaler.sv
// Multiplies a window sum by round(2^32/N) and rounds into the 32-bit output Q format.
module dec_scaler
    import decimator_pkg::*;
(
    input  logic                    Fg_CLK,
    input  logic                    RESETn,
    input  logic                    s1_valid,
    input  logic signed [ACC_W-1:0] s1_sum,
    input  logic [ML_W-1:0]         s1_mode,
    output logic [OUT_W-1:0]        dec_out,
    output logic                    dec_valid
);

    localparam logic signed [PROD_W-1:0] RND = PROD_W'(64'sd1 <<< (SHIFT - 1));

    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] prod;
    logic                     s2_valid;

    always_comb begin
        prod_c = PROD_W'(s1_sum) * PROD_W'($signed({1'b0, recip(s1_mode)}));
    end

    // Stage 2 holds the product, stage 3 the rounded result; both hold between windows.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            prod      <= '0;
            s2_valid  <= 1'b0;
            dec_out   <= '0;
            dec_valid <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            dec_valid <= s2_valid;
            if (s1_valid) prod <= prod_c;
            if (s2_valid) dec_out <= OUT_W'((prod + RND) >>> SHIFT);
        end
    end

endmodule

// File: rtl/decimator.sv
// Boxcar decimator: averages 10**Mode offset-binary ADC samples into one signed Q-format word.
module decimator
    import decimator_pkg::*;
(
    input  logic  Fg_CLK,
    input  logic  RESETn,
    decimator_if.slave bus
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] samp_x;
    logic signed [ACC_W-1:0] sum_c;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_base;
    logic [ML_W-1:0]         m_l;
    logic [ML_W-1:0]         m_eff;
    logic                    win_end_c;
    logic                    first_c;

    logic                    s1_valid;
    logic signed [ACC_W-1:0] s1_sum;
    logic [ML_W-1:0]         s1_mode;
    logic [OUT_W-1:0]        dec_out_w;
    logic                    dec_valid_w;

    // A sync in the same cycle as a sample makes that sample the first of a fresh window.
    always_comb begin
        samp_x    = ACC_W'(ob_to_s(bus.adc_in));
        acc_base  = bus.sync ? '0 : acc;
        cnt_base  = bus.sync ? '0 : cnt;
        first_c   = (cnt_base == '0);
        m_eff     = first_c ? clamp_mode(bus.Mode) : m_l;
        sum_c     = acc_base + samp_x;
        win_end_c = bus.adc_valid && (cnt_base == win_last(m_eff));
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            acc      <= '0;
            cnt      <= '0;
            m_l      <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_mode  <= '0;
        end else begin
            s1_valid <= win_end_c;
            if (bus.adc_valid) begin
                if (first_c) m_l <= m_eff;
                if (win_end_c) begin
                    s1_sum  <= sum_c;
                    s1_mode <= m_eff;
                    acc     <= '0;
                    cnt     <= '0;
                end else begin
                    acc     <= sum_c;
                    cnt     <= cnt_base + CNT_W'(1);
                end
            end else if (bus.sync) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end

    dec_scaler u_scaler (
        .Fg_CLK    (Fg_CLK),
        .RESETn    (RESETn),
        .s1_valid  (s1_valid),
        .s1_sum    (s1_sum),
        .s1_mode   (s1_mode),
        .dec_out   (dec_out_w),
        .dec_valid (dec_valid_w)
    );

    assign bus.dec_out   = dec_out_w;
    assign bus.dec_valid = dec_valid_w;

endmodule

// File: tb/tb_decimator.sv
// Scoreboard bench for decimator: stimulus pushes hand-computed results, a monitor checks value and cycle.
module tb_decimator;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic Fg_CLK = 1'b0;
    logic RESETn;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb[$];

    decimator_if bus();

    decimator dut (
        .Fg_CLK (Fg_CLK),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    always @(posedge Fg_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    // One input cycle; a sample seen in cycle k must produce its word during cycle k+3.
    task automatic send(input logic [11:0] a, input logic v, input logic s, input logic [3:0] m,
                        input logic ex, input logic [31:0] ev);
        exp_t e;
        @(negedge Fg_CLK);
        bus.adc_in    = a;
        bus.adc_valid = v;
        bus.sync      = s;
        bus.Mode      = m;
        if (ex) begin
            e.data = ev;
            e.cyc  = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n, input logic [3:0] m);
        for (int i = 0; i < n; i++) send(12'h123, 1'b0, 1'b0, m, 1'b0, 32'h0);
    endtask

    always @(negedge Fg_CLK) begin
        if (RESETn === 1'b1 && bus.dec_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_dec_valid: got dec_out 0x%08h with nothing expected (cycle %0d)",
                         bus.dec_out, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("dec_out", bus.dec_out, e.data);
                check("dec_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        RESETn        = 1'b0;
        bus.adc_in    = 12'h800;
        bus.adc_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.Mode      = 4'd0;
        repeat (2) @(negedge Fg_CLK);
        check("reset_dec_out", bus.dec_out, 32'h0);
        check("reset_dec_valid", 32'(bus.dec_valid), 32'h0);
        RESETn = 1'b1;
        idle(2, 4'd0);

        // Mode 0, full-scale positive every cycle: continuous strobes.
        for (int i = 0; i < 8; i++) send(12'hFFF, 1'b1, 1'b0, 4'd0, 1'b1, 32'h1FFC0000);
        idle(4, 4'd0);

        // Mode 1: full-scale negative, then mid-scale.
        for (int i = 0; i < 10; i++) send(12'h000, 1'b1, 1'b0, 4'd1, i == 9, 32'hE0000000);
        for (int i = 0; i < 10; i++) send(12'h800, 1'b1, 1'b0, 4'd1, i == 9, 32'h00000000);
        idle(4, 4'd1);

        // Mode 1 with gaps: +256 x5, -256 x5 -> mean 0.
        for (int i = 0; i < 10; i++) begin
            send((i < 5) ? 12'h900 : 12'h700, 1'b1, 1'b0, 4'd1, i == 9, 32'h00000000);
            idle(1, 4'd1);
        end
        idle(4, 4'd1);

        // Mode drops to 0 mid-window: window still spans 10 samples.
        for (int i = 0; i < 4; i++) send(12'hA00, 1'b1, 1'b0, 4'd1, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) send(12'hA00, 1'b1, 1'b0, 4'd0, i == 5, 32'h08000000);
        send(12'h801, 1'b1, 1'b0, 4'd0, 1'b1, 32'h00040000);
        send(12'h7FF, 1'b1, 1'b0, 4'd0, 1'b1, 32'hFFFC0000);
        idle(4, 4'd0);

        // Mode 0xF: long window, no output within 200 samples; then abandon it by sync.
        for (int i = 0; i < 200; i++) send(12'hFFF, 1'b1, 1'b0, 4'hF, 1'b0, 32'h0);
        send(12'h800, 1'b0, 1'b1, 4'hF, 1'b0, 32'h0);
        idle(4, 4'd1);

        // Sync aborts a partial window; the sync-cycle sample starts the new one.
        for (int i = 0; i < 6; i++) send(12'h000, 1'b1, 1'b0, 4'd1, 1'b0, 32'h0);
        send(12'hFFF, 1'b1, 1'b1, 4'd1, 1'b0, 32'h0);
        for (int i = 0; i < 9; i++) send(12'hFFF, 1'b1, 1'b0, 4'd1, i == 8, 32'h1FFC0000);
        idle(5, 4'd1);

        // Reset with one window in the pipeline and a new window started.
        for (int i = 0; i < 11; i++) send(12'hFFF, 1'b1, 1'b0, 4'd1, 1'b0, 32'h0);
        @(negedge Fg_CLK);
        RESETn        = 1'b0;
        bus.adc_valid = 1'b0;
        #1;
        check("rst_mid_dec_out", bus.dec_out, 32'h0);
        check("rst_mid_dec_valid", 32'(bus.dec_valid), 32'h0);
        @(negedge Fg_CLK);
        RESETn = 1'b1;
        idle(5, 4'd1);
        for (int i = 0; i < 10; i++) send(12'h900, 1'b1, 1'b0, 4'd1, i == 9, 32'h04000000);
        idle(6, 4'd1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge Fg_CLK);
        check("pending_results", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
